signed_divider: RTL
===================

Name: signed_divider

Overview:
- Multi-cycle 32-bit signed integer divider for the CPU's DIV path.
- Produces quotient and remainder for the HI/LO registers.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Performs start/done handshake with the execute stage.
- Complements the combinational signed comparison logic: this block resolves ordering iteratively rather than in one cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; all arithmetic and latency rules below scale with it.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  two's-complement dividend, sampled with start.
- divisor  input  WIDTH  two's-complement divisor, sampled with start.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  output  1  set with done when divisor == 0; held with results.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset mid-operation aborts the division; no done is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 in cycle T loads |dividend| and |divisor| into working registers.
  - Latches neg_q = dividend[WIDTH-1] XOR divisor[WIDTH-1] and neg_r = dividend[WIDTH-1].
  - Latches dz = (divisor == 0) and clears the counter; moves to RUN. busy=1 from T+1.
- RUN (cycles T+1 .. T+WIDTH):
  - Each edge shifts {rem, quo} left by one and brings in the next dividend bit.
  - If rem >= |divisor| (unsigned compare, WIDTH+1-bit subtract), rem -= |divisor| and quotient bit = 1; else quotient bit = 0.
  - Counter increments each step; after the WIDTH-th step, moves to FIX.
- FIX (cycle T+WIDTH+1):
  - Negates quo if neg_q, negates rem if neg_r.
  - Registers the results to the outputs; moves to DONE.
- DONE (cycle T+WIDTH+2):
  - done=1 for exactly this cycle, busy=1; then IDLE.
  - Total latency start to done = WIDTH+2 cycles (34 at default).
- Output holding: quotient/remainder/div_by_zero hold their values until the next accepted start completes. They are not cleared on the next start; they update only in FIX.
- Absolute value: abs(-2^(WIDTH-1)) = 2^(WIDTH-1), held as unsigned WIDTH bits (no overflow in the magnitude path).
- Overflow: -2^(WIDTH-1) / -1 gives quotient = 0x80000000 (wraps), remainder = 0, no flag.
- Divide by zero:
  - quotient = all ones (0xFFFFFFFF), remainder = original dividend, div_by_zero=1.
  - Same latency as a normal divide; the sign fix is bypassed for this case.
- start while busy (RUN/FIX/DONE) is ignored: no restart, operands not resampled.
- start in the same cycle done is high is ignored. A new start is accepted the following cycle (IDLE).
- Back-to-back throughput: one division per WIDTH+3 cycles.

Optional Feature:
- Macro: SIGNED_DIVIDER_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When 1, operands are taken as unsigned: no abs, neg_q=neg_r=0, FIX is a pass-through.
  - Divide-by-zero gives quotient all ones, remainder = dividend; latency is unchanged.
  - Supports DIVU.
- Not defined: port absent; all operations are signed.

Test Plan:
- dividend=100, divisor=7, start at T -> done only at T+34; quotient=14, remainder=2, div_by_zero=0; busy high T+1..T+34.
- Signed cases:
  - -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
  - 100/-7 -> quotient=-14, remainder=2.
  - -100/-7 -> quotient=14, remainder=-2.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Separately, 0x80000000 / 1 -> quotient=0x80000000, remainder=0.
- 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 at T+34. Next 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Busy-start interaction:
  - Start 100/7, pulse start with 1/1 at T+10 -> ignored; result still 14/2 at T+34.
  - Start 1/1 at T+35 -> accepted; done at T+69.
- Reset interaction:
  - Reset asserted at T+15 of 100/7 -> next cycle all outputs 0, state IDLE; no done pulse.
  - Subsequent start 6/4 -> quotient=1, remainder=2 after 34 cycles.

Source files
------------

// File: rtl/signed_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_divider_if
//  Description : Start/done handshake and operand/result bundle between the
//                execute stage (master) and the multi-cycle divider (slave).
//                When SIGNED_DIVIDER_UNSIGNED_EN is defined, the bundle also
//                carries the is_unsigned qualifier.
//  Revision    : 1.0  initial release
// ============================================================================
interface signed_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIVIDER_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
`ifdef SIGNED_DIVIDER_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
`ifdef SIGNED_DIVIDER_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : signed_divider
//  Description : Multi-cycle WIDTH-bit signed integer divider, restoring
//                shift-subtract, one quotient bit per clock. Quotient is
//                truncated toward zero, remainder takes the dividend's sign.
//                Start to done latency is WIDTH+2 cycles.
//                Optional macro SIGNED_DIVIDER_UNSIGNED_EN adds is_unsigned
//                (DIVU support).
//  Revision    : 1.0  initial release
// ============================================================================
module signed_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    signed_divider_if.slave     bus
);

    localparam int                  c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [WIDTH-1:0]   r_rem;          // partial remainder (magnitude)
    logic [WIDTH-1:0]   r_quo;          // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_dvs;          // |divisor|
    logic [WIDTH-1:0]   r_dvd_orig;     // original dividend, returned on divide-by-zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               w_busy;
    logic               w_done;

    logic               w_signed;
    logic               w_neg_dvd;
    logic               w_neg_dvs;
    logic [WIDTH-1:0]   w_abs_dvd;
    logic [WIDTH-1:0]   w_abs_dvs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

`ifdef SIGNED_DIVIDER_UNSIGNED_EN
    assign w_signed = ~bus.is_unsigned;
`else
    assign w_signed = 1'b1;
`endif

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign w_neg_dvd = w_signed & bus.dividend[WIDTH-1];
    assign w_neg_dvs = w_signed & bus.divisor[WIDTH-1];
    assign w_abs_dvd = w_neg_dvd ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_abs_dvs = w_neg_dvs ? (~bus.divisor + 1'b1) : bus.divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract with
    // an extra guard bit so the borrow decides the quotient bit.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[WIDTH+1];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start honoured only in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_next = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_state_next = c_FIX;
            c_FIX:   w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_RUN, c_FIX: w_busy = 1'b1;
            c_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dvd_orig    <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_rem      <= '0;
                        r_quo      <= w_abs_dvd;
                        r_dvs      <= w_abs_dvs;
                        r_dvd_orig <= bus.dividend;
                        r_neg_q    <= w_neg_dvd ^ w_neg_dvs;
                        r_neg_r    <= w_neg_dvd;
                        r_dz       <= (bus.divisor == '0);
                        r_cnt      <= '0;
                    end
                end
                c_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + c_ONE;
                end
                c_FIX: begin
                    // Divide-by-zero bypasses the sign fix entirely.
                    if (r_dz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dvd_orig;
                    end else begin
                        r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                        r_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                    end
                    r_div_by_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
